// File: rtl/clk_div_gen.sv
// Multi-channel clock-enable generator: each channel produces a divided waveform
// with programmable period, high time and start phase, switched glitch-free.

module clk_div_ch #(
    parameter int CNT_W     = 16,
    parameter int DEF_DIV   = 2,
    parameter int DEF_HIGH  = 1,
    parameter int DEF_PHASE = 0
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic             wr,
    input  logic [CNT_W-1:0] wr_div,
    input  logic [CNT_W-1:0] wr_high,
    input  logic [CNT_W-1:0] wr_phase,
    output logic             clk_out,
    output logic             rise_stb,
    output logic             active
);
    typedef struct packed {
        logic [CNT_W-1:0] div;
        logic [CNT_W-1:0] high;
        logic [CNT_W-1:0] phase;
    } cfg_t;

    typedef enum logic [1:0] {IDLE, DELAY, RUN, DRAIN} state_t;

    localparam cfg_t CFG_DEF = '{div:   CNT_W'(DEF_DIV),
                                 high:  CNT_W'(DEF_HIGH),
                                 phase: CNT_W'(DEF_PHASE)};

    state_t           state_q, state_d;
    cfg_t             shd_q, act_q, act_d, wr_cfg;
    logic [CNT_W-1:0] cnt_q, cnt_d, dly_q, dly_d;
    logic             wrap, running, clk_d, rise_d;

    function automatic cfg_t clamp(input cfg_t c);
        cfg_t r;
        r.div   = (c.div < CNT_W'(2)) ? CNT_W'(2) : c.div;
        r.high  = (c.high == '0) ? CNT_W'(1) :
                  (c.high >= r.div) ? r.div - CNT_W'(1) : c.high;
        r.phase = (c.phase >= r.div) ? r.div - CNT_W'(1) : c.phase;
        return r;
    endfunction

    assign wr_cfg  = '{div: wr_div, high: wr_high, phase: wr_phase};
    assign wrap    = (cnt_q == act_q.div - CNT_W'(1));
    assign running = (state_q == RUN) || (state_q == DRAIN);
    assign active  = (state_q != IDLE);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dly_d   = dly_q;
        act_d   = act_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                act_d = clamp(shd_q);
                if (en) begin
                    if (act_d.phase == '0) begin
                        state_d = RUN;
                    end else begin
                        state_d = DELAY;
                        dly_d   = act_d.phase - CNT_W'(1);
                    end
                end
            end
            DELAY: begin
                if (!en) begin
                    state_d = IDLE;
                end else if (dly_q == '0) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    dly_d = dly_q - CNT_W'(1);
                end
            end
            RUN, DRAIN: begin
                // A period never ends early: en only matters once the wrap edge arrives.
                if (wrap) begin
                    cnt_d   = '0;
                    act_d   = clamp(wr ? wr_cfg : shd_q);
                    state_d = en ? RUN : IDLE;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = en ? RUN : DRAIN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign clk_d  = running && (cnt_q < act_q.high);
    assign rise_d = running && (cnt_q == '0);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            dly_q    <= '0;
            shd_q    <= CFG_DEF;
            act_q    <= CFG_DEF;
            clk_out  <= 1'b0;
            rise_stb <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            dly_q    <= dly_d;
            act_q    <= act_d;
            clk_out  <= clk_d;
            rise_stb <= rise_d;
            if (wr) shd_q <= wr_cfg;
        end
    end
endmodule

module clk_div_gen #(
    parameter int NUM_CH    = 4,
    parameter int CNT_W     = 16,
    parameter int DEF_DIV   = 2,
    parameter int DEF_HIGH  = 1,
    parameter int DEF_PHASE = 0,
    localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [NUM_CH-1:0] en,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    input  logic [CNT_W-1:0]  cfg_high,
    input  logic [CNT_W-1:0]  cfg_phase,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] rise_stb,
    output logic [NUM_CH-1:0] active
);
    logic [NUM_CH-1:0] wr;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        // Out-of-range channel indices match no lane, so such writes fall away.
        assign wr[i] = cfg_we && (int'(cfg_ch) == i);

        clk_div_ch #(
            .CNT_W    (CNT_W),
            .DEF_DIV  (DEF_DIV),
            .DEF_HIGH (DEF_HIGH),
            .DEF_PHASE(DEF_PHASE)
        ) u_ch (
            .clk     (clk),
            .rstn    (rstn),
            .en      (en[i]),
            .wr      (wr[i]),
            .wr_div  (cfg_div),
            .wr_high (cfg_high),
            .wr_phase(cfg_phase),
            .clk_out (clk_out[i]),
            .rise_stb(rise_stb[i]),
            .active  (active[i])
        );
    end
endmodule
